// File: rtl/branch_resolve_unit.sv
// Two-stage elastic branch resolver. Stage 1 evaluates the branch condition,
// stage 2 forms the target, the redirect PC and the mispredict flag.
// Saturating counters track resolved branches and mispredicts.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 16,
    parameter int INSTR_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rdata1,
    input  logic [XLEN-1:0]  rdata2,
    input  logic [2:0]       br_type,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_BLTU = 3'b101;
    localparam logic [2:0] BR_BGEU = 3'b110;
    localparam logic [2:0] BR_JAL  = 3'b111;

    logic            s1_valid;
    logic            s1_taken;
    logic            s1_pred;
    logic [2:0]      s1_type;
    logic [XLEN-1:0] s1_pc;
    logic [XLEN-1:0] s1_imm;

    logic            s2_valid;
    logic            s2_taken;
    logic            s2_mispred;
    logic [2:0]      s2_type;
    logic [XLEN-1:0] s2_target;
    logic [XLEN-1:0] s2_redirect;

    logic            s1_advance;
    logic            s2_advance;
    logic            in_fire;
    logic            out_fire;
    logic            cmp_taken;
    logic [XLEN-1:0] s1_sum;

    // Handshake: a stage may load when it is empty or its contents move on;
    // input acceptance is held off for the whole time reset is asserted.
    always_comb begin
        s2_advance = !s2_valid || out_ready;
        s1_advance = !s1_valid || s2_advance;
        in_ready   = rst_n && s1_advance;
        in_fire    = in_valid && in_ready;
        out_fire   = s2_valid && out_ready && !flush;
        s1_sum     = s1_pc + s1_imm;
    end

    // Branch condition evaluation on the raw operands.
    always_comb begin
        cmp_taken = 1'b0;
        case (br_type)
            BR_NONE: cmp_taken = 1'b0;
            BR_BEQ:  cmp_taken = (rdata1 == rdata2);
            BR_BNE:  cmp_taken = (rdata1 != rdata2);
            BR_BLT:  cmp_taken = ($signed(rdata1) <  $signed(rdata2));
            BR_BGE:  cmp_taken = ($signed(rdata1) >= $signed(rdata2));
            BR_BLTU: cmp_taken = (rdata1 <  rdata2);
            BR_BGEU: cmp_taken = (rdata1 >= rdata2);
            BR_JAL:  cmp_taken = 1'b1;
            default: cmp_taken = 1'b0;
        endcase
    end

    // Stage 1 register: compare result plus the fields stage 2 needs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_taken <= 1'b0;
            s1_pred  <= 1'b0;
            s1_type  <= BR_NONE;
            s1_pc    <= '0;
            s1_imm   <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_advance) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_taken <= cmp_taken;
                s1_pred  <= pred_taken;
                s1_type  <= br_type;
                s1_pc    <= pc;
                s1_imm   <= imm;
            end
        end
    end

    // Stage 2 register: target, redirect and mispredict, held while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_taken    <= 1'b0;
            s2_mispred  <= 1'b0;
            s2_type     <= BR_NONE;
            s2_target   <= '0;
            s2_redirect <= '0;
        end else begin
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_advance) begin
                s2_valid <= s1_valid;
            end
            if (s2_advance && s1_valid) begin
                s2_taken    <= s1_taken;
                s2_type     <= s1_type;
                s2_target   <= s1_sum;
                s2_redirect <= s1_taken ? s1_sum : (s1_pc + XLEN'(INSTR_BYTES));
                s2_mispred  <= (s1_type != BR_NONE) && (s1_taken != s1_pred);
            end
        end
    end

    // Saturating performance counters, bumped only on a real consumer handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (out_fire && (s2_type != BR_NONE)) begin
            if (br_count != {CNT_W{1'b1}}) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (s2_mispred && (mispred_count != {CNT_W{1'b1}})) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

    assign out_valid   = s2_valid;
    assign br_taken    = s2_taken;
    assign br_target   = s2_target;
    assign redirect_pc = s2_redirect;
    assign mispredict  = s2_mispred;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus short random bench for branch_resolve_unit with a queue-based
// scoreboard fed on input handshakes and drained on output handshakes.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [2:0]  br_type;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] redirect_pc;
    logic        mispredict;
    logic [3:0]  br_count;
    logic [3:0]  mispred_count;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] redirect;
        logic        mispred;
        logic [2:0]  typ;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_br   = 0;
    int   m_mis  = 0;
    int   saved_br;
    int   saved_mis;

    branch_resolve_unit #(.XLEN(32), .CNT_W(4), .INSTR_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rdata1(rdata1), .rdata2(rdata2), .br_type(br_type), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .br_taken(br_taken), .br_target(br_target),
        .redirect_pc(redirect_pc), .mispredict(mispredict),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour of one branch beat.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] t, input logic [31:0] p,
                                   input logic [31:0] i, input logic pred);
        exp_t e;
        logic tk;
        case (t)
            3'd1:    tk = (a == b);
            3'd2:    tk = (a != b);
            3'd3:    tk = ($signed(a) < $signed(b));
            3'd4:    tk = ($signed(a) >= $signed(b));
            3'd5:    tk = (a < b);
            3'd6:    tk = (a >= b);
            3'd7:    tk = 1'b1;
            default: tk = 1'b0;
        endcase
        e.taken    = tk;
        e.target   = p + i;
        e.redirect = tk ? (p + i) : (p + 32'd4);
        e.mispred  = (t != 3'd0) && (tk != pred);
        e.typ      = t;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] t,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] i,
                                 input logic pred);
        in_valid   = v;
        br_type    = t;
        rdata1     = a;
        rdata2     = b;
        pc         = p;
        imm        = i;
        pred_taken = pred;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drainPipe();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            waitCycle();
        end
        checkOutput("drain_empty", 64'(sb.size() == 0 && !out_valid), 64'd1);
    endtask

    // Scoreboard monitor: push expected results on input handshakes, compare on
    // output handshakes, and verify held outputs while the consumer stalls.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_br  = 0;
            m_mis = 0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 64'd0, 64'd1);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    checkOutput("sb_taken",    64'(br_taken),    64'(e.taken));
                    checkOutput("sb_target",   64'(br_target),   64'(e.target));
                    checkOutput("sb_redirect", 64'(redirect_pc), 64'(e.redirect));
                    checkOutput("sb_mispred",  64'(mispredict),  64'(e.mispred));
                    if (e.typ != 3'd0) begin
                        if (m_br < 15) m_br++;
                        if (e.mispred && m_mis < 15) m_mis++;
                    end
                end else begin
                    checkOutput("stall_target",   64'(br_target),   64'(sb[0].target));
                    checkOutput("stall_redirect", 64'(redirect_pc), 64'(sb[0].redirect));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(rdata1, rdata2, br_type, pc, imm, pred_taken));
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by a short random burst.
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        waitCycle();
        waitCycle();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_br_count",  64'(br_count), 64'd0);
        checkOutput("rst_mis_count", 64'(mispred_count), 64'd0);
        checkOutput("rst_in_ready",  64'(in_ready), 64'd0);
        rst_n = 1'b1;
        waitCycle();
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] back-to-back BEQ/BNE");
        applyStimulus(1'b1, 3'b001, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 3'b010, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        waitCycle();
        checkOutput("beq_valid",    64'(out_valid), 64'd1);
        checkOutput("beq_taken",    64'(br_taken), 64'd1);
        checkOutput("beq_target",   64'(br_target), 64'h120);
        checkOutput("beq_redirect", 64'(redirect_pc), 64'h120);
        checkOutput("beq_mispred",  64'(mispredict), 64'd1);
        in_valid = 1'b0;
        waitCycle();
        checkOutput("bne_taken",    64'(br_taken), 64'd0);
        checkOutput("bne_redirect", 64'(redirect_pc), 64'h104);
        checkOutput("bne_mispred",  64'(mispredict), 64'd0);
        waitCycle();
        checkOutput("t1_drained",   64'(out_valid), 64'd0);
        checkOutput("t1_br_count",  64'(br_count), 64'd2);
        checkOutput("t1_mis_count", 64'(mispred_count), 64'd1);

        $display("[TB] signed versus unsigned compares");
        applyStimulus(1'b1, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b0);
        waitCycle();
        checkOutput("blt_taken", 64'(br_taken), 64'd1);
        applyStimulus(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b0);
        waitCycle();
        checkOutput("bltu_taken", 64'(br_taken), 64'd0);
        applyStimulus(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b0);
        waitCycle();
        checkOutput("bge_taken", 64'(br_taken), 64'd0);
        in_valid = 1'b0;
        waitCycle();
        checkOutput("bgeu_taken", 64'(br_taken), 64'd1);
        drainPipe();

        $display("[TB] equal operands across all encodings");
        for (int t = 0; t < 8; t++) begin
            applyStimulus(1'b1, 3'(t), 32'd7, 32'd7, 32'h240 + 32'(t * 4), 32'h30,
                          1'($urandom_range(0, 1)));
            waitCycle();
        end
        drainPipe();

        $display("[TB] random traffic with stalls and flushes");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          $urandom(), $urandom(), $urandom(), $urandom(),
                          1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 9) == 0);
            waitCycle();
        end
        drainPipe();
        checkOutput("rand_br_count",  64'(br_count), 64'(m_br));
        checkOutput("rand_mis_count", 64'(mispred_count), 64'(m_mis));

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'b111, 32'd0, 32'd0, 32'h300, 32'h10, 1'b1);
        waitCycle();
        checkOutput("bp_in_ready_1", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 3'b111, 32'd0, 32'd0, 32'h310, 32'h10, 1'b1);
        waitCycle();
        checkOutput("bp_in_ready_2", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid",  64'(out_valid), 64'd1);
        applyStimulus(1'b1, 3'b111, 32'd0, 32'd0, 32'h320, 32'h10, 1'b1);
        waitCycle();
        checkOutput("bp_in_ready_3", 64'(in_ready), 64'd0);
        checkOutput("bp_frozen",     64'(br_target), 64'h310);
        out_ready = 1'b1;
        waitCycle();
        checkOutput("bp_second_out", 64'(br_target), 64'h320);
        in_valid = 1'b0;
        waitCycle();
        checkOutput("bp_third_out",  64'(br_target), 64'h330);
        drainPipe();

        $display("[TB] flush with both stages full");
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'b001, 32'd3, 32'd3, 32'h500, 32'h10, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 3'b001, 32'd3, 32'd4, 32'h504, 32'h10, 1'b1);
        waitCycle();
        checkOutput("fl_full_ready", 64'(in_ready), 64'd0);
        saved_br  = m_br;
        saved_mis = m_mis;
        applyStimulus(1'b1, 3'b111, 32'd0, 32'd0, 32'h508, 32'h10, 1'b0);
        flush     = 1'b1;
        out_ready = 1'b1;
        waitCycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_br_count",  64'(br_count), 64'(saved_br));
        checkOutput("fl_mis_count", 64'(mispred_count), 64'(saved_mis));
        checkOutput("fl_in_ready",  64'(in_ready), 64'd1);
        waitCycle();
        checkOutput("fl_dropped",   64'(out_valid), 64'd0);

        $display("[TB] target wrap and counter saturation");
        applyStimulus(1'b1, 3'b111, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20, 1'b1);
        waitCycle();
        in_valid = 1'b0;
        waitCycle();
        checkOutput("wrap_target",   64'(br_target), 64'h10);
        checkOutput("wrap_redirect", 64'(redirect_pc), 64'h10);
        checkOutput("wrap_mispred",  64'(mispredict), 64'd0);
        drainPipe();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 3'b001, 32'd1, 32'd2, 32'(i * 4), 32'h40, 1'b1);
            waitCycle();
        end
        drainPipe();
        checkOutput("sat_br_count",  64'(br_count), 64'd15);
        checkOutput("sat_mis_count", 64'(mispred_count), 64'd15);

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'b001, 32'd9, 32'd9, 32'h600, 32'h10, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 3'b001, 32'd9, 32'd9, 32'h604, 32'h10, 1'b0);
        waitCycle();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        waitCycle();
        checkOutput("mr_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mr_br_count",  64'(br_count), 64'd0);
        checkOutput("mr_mis_count", 64'(mispred_count), 64'd0);
        checkOutput("mr_in_ready",  64'(in_ready), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        waitCycle();
        checkOutput("mr_in_ready_after", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 3'b101, 32'd1, 32'd2, 32'h400, 32'h40, 1'b0);
        waitCycle();
        in_valid = 1'b0;
        waitCycle();
        checkOutput("mr_taken",    64'(br_taken), 64'd1);
        checkOutput("mr_target",   64'(br_target), 64'h440);
        checkOutput("mr_redirect", 64'(redirect_pc), 64'h440);
        checkOutput("mr_mispred",  64'(mispredict), 64'd1);
        drainPipe();
        checkOutput("mr_br_count_final",  64'(br_count), 64'd1);
        checkOutput("mr_mis_count_final", 64'(mispred_count), 64'd1);
        checkOutput("final_model_br",     64'(br_count), 64'(m_br));
        checkOutput("final_model_mis",    64'(mispred_count), 64'(m_mis));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
